// File: rtl/axi_st_fifo_src_if.sv
// AXI-ST handshake bundle between the FIFO source (master) and its sink (slave).
interface axi_st_fifo_src_if #(
    parameter int unsigned DATA_W = 64
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              rdy;

    modport master (output valid, output data, input rdy);
    modport slave  (input valid, input data, output rdy);
endinterface

// File: rtl/axi_st_fifo_src.sv
// FIFO-to-AXI-ST source. FIFO reads are issued only while the words already in flight plus
// the words held in the skid buffer leave room for one more, so a read can always land even
// when the sink stalls. The buffer head is presented on AXI-ST.
module axi_st_fifo_src #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           fifo_empty,
    output logic                           fifo_rden,
    input  logic [DATA_W-1:0]              fifo_rdata,
    axi_st_fifo_src_if.master              axist,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_level,
    output logic [CNT_W-1:0]               beat_cnt,
    output logic                           idle
);
    localparam int unsigned LVL_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = LVL_W + 1;
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned INF_W = $clog2(RD_LAT + 1);

    logic [RD_LAT-1:0] vld_sr_q;
    logic [INF_W-1:0]  inflight;
    logic [SUM_W-1:0]  credit_used;
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic              valid_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              push;
    logic              pop;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Count reads still travelling through the FIFO read pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + INF_W'(vld_sr_q[i]);
        end
    end

    // Registered occupancy only, so no path from axist.rdy to the read strobe.
    assign credit_used = SUM_W'(inflight) + SUM_W'(level_q);
    assign fifo_rden   = rst_n & enable & ~fifo_empty & (credit_used < SUM_W'(BUF_DEPTH));

    assign push = vld_sr_q[RD_LAT-1];
    assign pop  = valid_q & axist.rdy;

    // Shift the read strobe along; the tail marks the cycle its data is on fifo_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q[0] <= fifo_rden;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
            end
        end
    end

    // Skid buffer storage; cleared on reset so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= fifo_rdata;
        end
    end

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    // Pointers, occupancy, registered valid and the accepted-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            level_q    <= level_d;
            valid_q    <= (level_d != '0);
            beat_cnt_q <= beat_cnt_q + CNT_W'(pop);
        end
    end

    assign axist.valid = valid_q;
    assign axist.data  = mem_q[rd_ptr_q];
    assign buf_level   = level_q;
    assign beat_cnt    = beat_cnt_q;
    assign idle        = (vld_sr_q == '0) && (level_q == '0);

endmodule

// File: tb/tb_axi_st_fifo_src.sv
// Bench for axi_st_fifo_src: two instances (RD_LAT=2/BUF_DEPTH=4 and RD_LAT=4/BUF_DEPTH=6/
// CNT_W=4) fed by behavioural read-latency FIFOs. A scoreboard tracks every word read from
// each FIFO together with the cycle it must become visible at the output.
module tb_axi_st_fifo_src;
    localparam int NW = 256;
    localparam logic [63:0] GARB = 64'hDEAD_BEEF_0BAD_F00D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Stimulus and FIFO contents
    logic        en    [2];
    logic        rdy   [2];
    logic [63:0] words [2][NW];
    int          nw    [2];
    int          head  [2];
    logic [63:0] p0    [2];
    logic [63:0] p1    [4];

    // DUT-facing signals
    logic        fe0, fe1, rden0, rden1, idle0, idle1;
    logic [2:0]  lvl0, lvl1;
    logic [15:0] bc0;
    logic [3:0]  bc1;

    axi_st_fifo_src_if #(.DATA_W(64)) ax0 ();
    axi_st_fifo_src_if #(.DATA_W(64)) ax1 ();

    assign fe0     = (head[0] >= nw[0]);
    assign fe1     = (head[1] >= nw[1]);
    assign ax0.rdy = rdy[0];
    assign ax1.rdy = rdy[1];

    axi_st_fifo_src #(.DATA_W(64), .RD_LAT(2), .BUF_DEPTH(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(fe0), .fifo_rden(rden0),
        .fifo_rdata(p0[1]), .axist(ax0), .buf_level(lvl0), .beat_cnt(bc0), .idle(idle0)
    );

    axi_st_fifo_src #(.DATA_W(64), .RD_LAT(4), .BUF_DEPTH(6), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(fe1), .fifo_rden(rden1),
        .fifo_rdata(p1[3]), .axist(ax1), .buf_level(lvl1), .beat_cnt(bc1), .idle(idle1)
    );

    // Behavioural FIFOs: a read pops the next word, which appears RD_LAT cycles later.
    always @(posedge clk) begin
        if (rden0) head[0] <= head[0] + 1;
        if (rden1) head[1] <= head[1] + 1;
        p0[0] <= rden0 ? words[0][head[0]] : GARB;
        p0[1] <= p0[0];
        p1[0] <= rden1 ? words[1][head[1]] : GARB;
        for (int k = 1; k < 4; k++) p1[k] <= p1[k-1];
    end

    logic        o_rden [2];
    logic        o_vld  [2];
    logic        o_idle [2];
    logic [63:0] o_data [2];
    logic [63:0] o_lvl  [2];
    logic [63:0] o_bc   [2];
    assign o_rden[0] = rden0;     assign o_rden[1] = rden1;
    assign o_vld[0]  = ax0.valid; assign o_vld[1]  = ax1.valid;
    assign o_idle[0] = idle0;     assign o_idle[1] = idle1;
    assign o_data[0] = ax0.data;  assign o_data[1] = ax1.data;
    assign o_lvl[0]  = 64'(lvl0); assign o_lvl[1]  = 64'(lvl1);
    assign o_bc[0]   = 64'(bc0);  assign o_bc[1]   = 64'(bc1);

    // Scoreboard: words[g][sh..head-1] are read but not yet accepted; arr = visible-from cycle.
    int sh  [2];
    int arr [2][NW];
    int acc [2];
    int nrd [2];
    int cyc;
    int obs_cyc;
    logic        obs_rden [2];
    logic        obs_vld  [2];
    logic        obs_beat [2];
    logic        obs_idle [2];
    logic [63:0] obs_data [2];
    logic [63:0] obs_lvl  [2];
    logic [63:0] obs_bc   [2];
    int n_chk;
    int n_fail;

    typedef struct {
        int inst;
        int nwords;
        int rdy_pct;
        int en_pct;
        int exp_beats;
    } vec_t;
    vec_t vecs [5];

    function automatic int rl(input int g);  return (g == 0) ? 2 : 4;  endfunction
    function automatic int dep(input int g); return (g == 0) ? 4 : 6;  endfunction
    function automatic int cw(input int g);  return (g == 0) ? 16 : 4; endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare both instances against the scoreboard, then advance it for the coming edge.
    task automatic monitor();
        for (int g = 0; g < 2; g++) begin
            int out;
            int nr;
            logic erden;
            obs_rden[g] = o_rden[g];
            obs_vld[g]  = o_vld[g];
            obs_idle[g] = o_idle[g];
            obs_data[g] = o_data[g];
            obs_lvl[g]  = o_lvl[g];
            obs_bc[g]   = o_bc[g];
            obs_beat[g] = 1'b0;
            if (!rst_n) begin
                chk($sformatf("i%0d_rst_rden", g), 64'(o_rden[g]), 64'd0);
                chk($sformatf("i%0d_rst_valid", g), 64'(o_vld[g]), 64'd0);
                chk($sformatf("i%0d_rst_data", g), o_data[g], 64'd0);
                chk($sformatf("i%0d_rst_level", g), o_lvl[g], 64'd0);
                chk($sformatf("i%0d_rst_beat_cnt", g), o_bc[g], 64'd0);
                chk($sformatf("i%0d_rst_idle", g), 64'(o_idle[g]), 64'd1);
                sh[g]  = head[g];
                acc[g] = 0;
            end else begin
                out = head[g] - sh[g];
                nr  = 0;
                for (int i = sh[g]; i < head[g]; i++) if (arr[g][i] <= cyc) nr++;
                erden = en[g] && (head[g] < nw[g]) && (out < dep(g));
                chk($sformatf("i%0d_rden", g), 64'(o_rden[g]), 64'(erden));
                chk($sformatf("i%0d_valid", g), 64'(o_vld[g]), 64'(nr > 0));
                chk($sformatf("i%0d_level", g), o_lvl[g], 64'(nr));
                chk($sformatf("i%0d_level_bound", g), 64'(o_lvl[g] <= 64'(dep(g))), 64'd1);
                chk($sformatf("i%0d_idle", g), 64'(o_idle[g]), 64'(out == 0));
                chk($sformatf("i%0d_beat_cnt", g), o_bc[g], 64'(acc[g] % (1 << cw(g))));
                if (nr > 0) chk($sformatf("i%0d_data", g), o_data[g], words[g][sh[g]]);
                if (o_rden[g]) begin
                    arr[g][head[g]] = cyc + rl(g) + 1;
                    nrd[g]++;
                end
                obs_beat[g] = o_vld[g] && rdy[g] && (nr > 0);
                if (obs_beat[g]) begin
                    sh[g]++;
                    acc[g]++;
                end
            end
        end
        obs_cyc = cyc;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int g, input int n);
        for (int i = 0; i < n; i++) words[g][nw[g] + i] = {$urandom(), $urandom()};
        nw[g] += n;
    endtask

    initial begin
        int fr, fv, fb, lb, n0, a0, base;
        logic hit;
        vecs[0] = '{0, 24, 50, 80, 24};
        vecs[1] = '{0, 30, 90, 50, 30};
        vecs[2] = '{1, 40, 30, 100, 40};
        vecs[3] = '{1, 25, 70, 60, 25};
        vecs[4] = '{0, 12, 10, 100, 12};
        en = '{1'b0, 1'b0};
        rdy = '{1'b0, 1'b0};
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 8 words, rdy=1: first valid 3 cycles after first rden, 8 back-to-back beats
        load(0, 8);
        en[0] = 1'b1; rdy[0] = 1'b1;
        fr = -1; fv = -1; fb = -1; lb = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (obs_rden[0] && fr < 0) fr = obs_cyc;
            if (obs_vld[0] && fv < 0) fv = obs_cyc;
            if (obs_beat[0]) begin
                if (fb < 0) fb = obs_cyc;
                lb = obs_cyc;
            end
        end
        chk("t1_latency", 64'(fv - fr), 64'd3);
        chk("t1_consecutive", 64'(lb - fb), 64'd7);
        chk("t1_beat_cnt", obs_bc[0], 64'd8);
        chk("t1_idle", 64'(obs_idle[0]), 64'd1);
        en[0] = 1'b0;

        // rdy=0: exactly BUF_DEPTH reads, head word held, then full delivery
        base = nw[0];
        load(0, 8);
        n0 = nrd[0]; a0 = acc[0];
        en[0] = 1'b1; rdy[0] = 1'b0;
        repeat (20) tick();
        chk("t2_rdens", 64'(nrd[0] - n0), 64'd4);
        chk("t2_level", obs_lvl[0], 64'd4);
        chk("t2_valid", 64'(obs_vld[0]), 64'd1);
        chk("t2_head", obs_data[0], words[0][base]);
        rdy[0] = 1'b1;
        repeat (30) tick();
        chk("t2_beats", 64'(acc[0] - a0), 64'd8);
        chk("t2_idle", 64'(obs_idle[0]), 64'd1);

        // rdy toggling with 16 words
        load(0, 16);
        a0 = acc[0];
        for (int i = 0; i < 80; i++) begin
            rdy[0] = (i % 2 == 0);
            tick();
        end
        chk("t3_beats", 64'(acc[0] - a0), 64'd16);
        chk("t3_idle", 64'(obs_idle[0]), 64'd1);
        en[0] = 1'b0; rdy[0] = 1'b1;

        // enable for 3 read cycles only
        load(0, 8);
        n0 = nrd[0]; a0 = acc[0];
        en[0] = 1'b1;
        repeat (3) tick();
        en[0] = 1'b0;
        repeat (20) tick();
        chk("t4_rdens", 64'(nrd[0] - n0), 64'd3);
        chk("t4_beats", 64'(acc[0] - a0), 64'd3);
        chk("t4_valid", 64'(obs_vld[0]), 64'd0);
        chk("t4_idle", 64'(obs_idle[0]), 64'd1);
        en[0] = 1'b1;
        repeat (20) tick();
        en[0] = 1'b0;

        // reset with level=2 and 2 reads in flight
        base = nw[0];
        load(0, 8);
        en[0] = 1'b1; rdy[0] = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            #1;
            hit = (o_lvl[0] == 64'd2);
        end
        chk("t5_reach_level2", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_now_rden", 64'(o_rden[0]), 64'd0);
        chk("t5_now_valid", 64'(o_vld[0]), 64'd0);
        chk("t5_now_data", o_data[0], 64'd0);
        chk("t5_now_level", o_lvl[0], 64'd0);
        chk("t5_now_beat_cnt", o_bc[0], 64'd0);
        chk("t5_now_idle", 64'(o_idle[0]), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        rdy[0] = 1'b1;
        fb = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (obs_beat[0] && fb < 0) begin
                fb = obs_cyc;
                chk("t5_first_after_reset", obs_data[0], words[0][base + 4]);
            end
        end
        chk("t5_beat_cnt", obs_bc[0], 64'd4);
        chk("t5_idle", 64'(obs_idle[0]), 64'd1);
        en[0] = 1'b0;

        // RD_LAT=4, BUF_DEPTH=6, CNT_W=4: sustained 1 beat/clk, counter wraps
        load(1, 20);
        en[1] = 1'b1; rdy[1] = 1'b1;
        fb = -1; lb = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (obs_beat[1]) begin
                if (fb < 0) fb = obs_cyc;
                lb = obs_cyc;
            end
        end
        chk("t6_sustained", 64'(lb - fb), 64'd19);
        chk("t6_beat_cnt_wrap", obs_bc[1], 64'd4);
        chk("t6_idle", 64'(obs_idle[1]), 64'd1);
        en[1] = 1'b0;

        // Randomised enable/ready vectors, then a full drain
        for (int v = 0; v < 5; v++) begin
            int g;
            g = vecs[v].inst;
            a0 = acc[g];
            load(g, vecs[v].nwords);
            for (int c = 0; c < 60; c++) begin
                en[g]  = ($urandom_range(99) < 32'(vecs[v].en_pct));
                rdy[g] = ($urandom_range(99) < 32'(vecs[v].rdy_pct));
                tick();
            end
            en[g] = 1'b1; rdy[g] = 1'b1;
            repeat (80) tick();
            chk($sformatf("vec%0d_beats", v), 64'(acc[g] - a0), 64'(vecs[v].exp_beats));
            chk($sformatf("vec%0d_idle", v), 64'(obs_idle[g]), 64'd1);
            chk($sformatf("vec%0d_fifo_drained", v), 64'(head[g]), 64'(nw[g]));
            en[g] = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
